// File: rtl/cursor_pkg.sv
// Shared types and constants for the cursor navigator: select FSM states and
// board geometry with wrap-around helpers.
package cursor_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SRC_HELD = 1'b1
    } sel_state_t;

    localparam logic [2:0] BOARD_MAX = 3'd7;

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == BOARD_MAX) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] wrap_dec(input logic [2:0] v);
        return (v == 3'd0) ? BOARD_MAX : v - 3'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// registered rising-edge detector producing a single-clock press pulse.
module button_debounce
    import cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/cursor_nav.sv
// Board cursor driven by five debounced buttons, with a two-step select FSM
// that latches a source square and then a destination square as a move.
module cursor_nav
    import cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [2:0] cursor_row,
    output logic [2:0] cursor_col,
    output logic       src_held,
    output logic [2:0] src_row,
    output logic [2:0] src_col,
    output logic [2:0] dst_row,
    output logic [2:0] dst_col,
    output logic       move_valid
);

    logic w_up, w_down, w_left, w_right, w_sel;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset(reset), .i_btn(btn_up), .o_press(w_up)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .reset(reset), .i_btn(btn_down), .o_press(w_down)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .reset(reset), .i_btn(btn_left), .o_press(w_left)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .reset(reset), .i_btn(btn_right), .o_press(w_right)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk(clk), .reset(reset), .i_btn(btn_sel), .o_press(w_sel)
    );

    sel_state_t r_state;
    sel_state_t w_state_next;
    logic       w_latch_src;
    logic       w_latch_dst;
    logic       w_on_src;

    logic [2:0] r_row, r_col;
    logic [2:0] r_src_row, r_src_col;
    logic [2:0] r_dst_row, r_dst_col;
    logic       r_move_valid;

    // Compare against the registered cursor so a coincident move uses the old square.
    assign w_on_src = (r_row == r_src_row) && (r_col == r_src_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_src  = 1'b0;
        w_latch_dst  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel) begin
                    w_latch_src  = 1'b1;
                    w_state_next = SRC_HELD;
                end
            end
            SRC_HELD: begin
                if (w_sel) begin
                    w_state_next = IDLE;
                    w_latch_dst  = !w_on_src;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row        <= 3'd0;
            r_col        <= 3'd0;
            r_src_row    <= 3'd0;
            r_src_col    <= 3'd0;
            r_dst_row    <= 3'd0;
            r_dst_col    <= 3'd0;
            r_move_valid <= 1'b0;
        end else begin
            if (w_up && !w_down) begin
                r_row <= wrap_dec(r_row);
            end else if (w_down && !w_up) begin
                r_row <= wrap_inc(r_row);
            end
            if (w_left && !w_right) begin
                r_col <= wrap_dec(r_col);
            end else if (w_right && !w_left) begin
                r_col <= wrap_inc(r_col);
            end
            if (w_latch_src) begin
                r_src_row <= r_row;
                r_src_col <= r_col;
            end
            if (w_latch_dst) begin
                r_dst_row <= r_row;
                r_dst_col <= r_col;
            end
            r_move_valid <= w_latch_dst;
        end
    end

    assign cursor_row = r_row;
    assign cursor_col = r_col;
    assign src_row    = r_src_row;
    assign src_col    = r_src_col;
    assign dst_row    = r_dst_row;
    assign dst_col    = r_dst_col;
    assign move_valid = r_move_valid;
    assign src_held   = (r_state == SRC_HELD);

endmodule

// File: tb/tb_cursor_nav.sv
// Bench for cursor_nav: directed scenarios plus random button activity, all
// checked every cycle against a sample-window reference model.
module tb_cursor_nav;

    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;   // 0 up, 1 down, 2 left, 3 right, 4 sel
    logic [2:0] cursor_row, cursor_col, src_row, src_col, dst_row, dst_col;
    logic       src_held, move_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int n_mv    = 0;
    int mv0     = 0;
    int cyc     = 0;

    bit samp [5][MAXC];
    bit lvl  [5][MAXC];
    int m_row, m_col, m_srow, m_scol, m_drow, m_dcol;
    bit m_held, m_mv;

    always #5 clk = ~clk;

    cursor_nav #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
        .btn_right(btn[3]), .btn_sel(btn[4]),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .src_held(src_held),
        .src_row(src_row), .src_col(src_col),
        .dst_row(dst_row), .dst_col(dst_col),
        .move_valid(move_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {12'd0, cursor_row, cursor_col, src_row, src_col,
                dst_row, dst_col, move_valid, src_held};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {12'd0, m_row[2:0], m_col[2:0], m_srow[2:0], m_scol[2:0],
                m_drow[2:0], m_dcol[2:0], m_mv, m_held};
    endfunction

    function automatic bit samp_at(input int b, input int k);
        return (k < 0) ? 1'b0 : samp[b][k % MAXC];
    endfunction

    function automatic bit lvl_at(input int b, input int k);
        return (k < 0) ? 1'b0 : lvl[b][k % MAXC];
    endfunction

    task automatic model_reset();
        cyc = 0;
        m_row = 0; m_col = 0; m_srow = 0; m_scol = 0; m_drow = 0; m_dcol = 0;
        m_held = 1'b0; m_mv = 1'b0;
    endtask

    // A debounced level flips once the last D synchronized samples (raw samples
    // two clocks old) all disagree with it; a press acts two clocks after the rise.
    task automatic model_step();
        bit press [5];
        bit prev, all_diff;
        for (int b = 0; b < 5; b++) begin
            samp[b][cyc % MAXC] = btn[b];
            prev = lvl_at(b, cyc - 1);
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                if (samp_at(b, cyc - j) == prev) all_diff = 1'b0;
            end
            lvl[b][cyc % MAXC] = all_diff ? ~prev : prev;
            press[b] = lvl_at(b, cyc - 2) && !lvl_at(b, cyc - 3);
        end
        m_mv = 1'b0;
        if (press[4]) begin
            if (!m_held) begin
                m_srow = m_row; m_scol = m_col; m_held = 1'b1;
            end else if (m_row == m_srow && m_col == m_scol) begin
                m_held = 1'b0;
            end else begin
                m_drow = m_row; m_dcol = m_col; m_mv = 1'b1; m_held = 1'b0;
            end
        end
        if (press[0] && !press[1]) m_row = (m_row + 7) % 8;
        else if (press[1] && !press[0]) m_row = (m_row + 1) % 8;
        if (press[2] && !press[3]) m_col = (m_col + 7) % 8;
        else if (press[3] && !press[2]) m_col = (m_col + 1) % 8;
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            model_step();
            chk("model", obs_vec(), exp_vec());
        end
        if (move_valid) n_mv++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_btn(input logic [4:0] mask);
        btn = btn | mask;
        ticks(10);
        btn = btn & ~mask;
        ticks(10);
    endtask

    initial begin
        btn   = 5'd0;
        reset = 1'b1;
        #12;
        chk("rst_out", obs_vec(), 32'd0);
        tick();
        model_reset();
        reset = 1'b0;

        // Latency from a clean edge: row moves on the 7th clock after it.
        btn[1] = 1'b1;
        ticks(7);
        chk("lat_pre", 32'(cursor_row), 32'd0);
        tick();
        chk("lat_post", 32'(cursor_row), 32'd1);
        ticks(2);
        btn[1] = 1'b0;
        ticks(10);
        repeat (7) press_btn(5'b00010);
        chk("down_wrap", 32'(cursor_row), 32'd0);

        press_btn(5'b00001);
        chk("up_wrap", 32'(cursor_row), 32'd7);
        press_btn(5'b00100);
        chk("left_wrap", 32'(cursor_col), 32'd7);
        press_btn(5'b00010);
        press_btn(5'b01000);
        chk("home", {26'd0, cursor_row, cursor_col}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            btn[3] = 1'b1; ticks(2);
            btn[3] = 1'b0; ticks(2);
        end
        btn[3] = 1'b1; ticks(10);
        btn[3] = 1'b0; ticks(10);
        chk("bounce", 32'(cursor_col), 32'd1);

        press_btn(5'b00011);
        chk("ud_same", 32'(cursor_row), 32'd0);
        press_btn(5'b01001);
        chk("ur_row", 32'(cursor_row), 32'd7);
        chk("ur_col", 32'(cursor_col), 32'd2);

        repeat (3) press_btn(5'b00010);
        press_btn(5'b01000);
        chk("at_23", {26'd0, cursor_row, cursor_col}, {26'd0, 3'd2, 3'd3});
        press_btn(5'b10000);
        chk("held", 32'(src_held), 32'd1);
        chk("src", {26'd0, src_row, src_col}, {26'd0, 3'd2, 3'd3});
        repeat (2) press_btn(5'b00010);
        mv0 = n_mv;
        press_btn(5'b10000);
        chk("mv_once", n_mv - mv0, 32'd1);
        chk("dst", {26'd0, dst_row, dst_col}, {26'd0, 3'd4, 3'd3});
        chk("src_keep", {26'd0, src_row, src_col}, {26'd0, 3'd2, 3'd3});
        chk("held_clr", 32'(src_held), 32'd0);

        mv0 = n_mv;
        press_btn(5'b10000);
        chk("held2", 32'(src_held), 32'd1);
        press_btn(5'b10000);
        chk("cancel_held", 32'(src_held), 32'd0);
        chk("cancel_mv", n_mv - mv0, 32'd0);
        chk("cancel_dst", {26'd0, dst_row, dst_col}, {26'd0, 3'd4, 3'd3});

        // Reset while holding a source and mid-debounce of a down press.
        press_btn(5'b10000);
        chk("held3", 32'(src_held), 32'd1);
        btn[1] = 1'b1;
        ticks(3);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", obs_vec(), 32'd0);
        mv0 = n_mv;
        ticks(2);
        model_reset();
        reset = 1'b0;
        ticks(10);
        btn[1] = 1'b0;
        ticks(10);
        chk("rst_nomv", n_mv - mv0, 32'd0);
        chk("rst_press", 32'(cursor_row), 32'd1);
        chk("rst_idle", 32'(src_held), 32'd0);

        repeat (600) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            end
            tick();
        end
        btn = 5'd0;
        ticks(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_nav.md
CURSOR_NAV -- requirements
Module: cursor_nav

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, which is the number of consecutive stable clocks a button must hold before its debounced level changes (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports btn_up, btn_down, btn_left, btn_right and btn_sel, each input, 1 bit: raw push-buttons, asynchronous to clk and bouncy.
REQ-005 SHALL have ports cursor_row and cursor_col, each output, 3 bits: the current board square, 0..7.
REQ-006 SHALL have port src_held, output, 1 bit: high while a source square is latched.
REQ-007 SHALL have ports src_row, src_col, dst_row and dst_col, each output, 3 bits: the squares of the last completed or pending move.
REQ-008 SHALL have port move_valid, output, 1 bit: a one-clock pulse when a move completes.

Function
REQ-009 SHALL pass each button through a 2-flop synchronizer, then a debounce counter, then a rising-edge detector that yields a one-clock press pulse.
REQ-010 SHALL toggle a button's debounced level only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive clocks; any return to the old level clears the counter.
REQ-011 SHALL fix the latency from a clean raw rising edge (setup met at clock edge 0) to the cursor or FSM reacting at exactly DEBOUNCE_CYCLES+3 clocks.
REQ-012 SHALL, on an up pulse, decrement cursor_row mod 8 (0 -> 7); on a down pulse, increment cursor_row mod 8 (7 -> 0).
REQ-013 SHALL, on a left pulse, decrement cursor_col mod 8 (0 -> 7); on a right pulse, increment cursor_col mod 8 (7 -> 0).
REQ-014 SHALL leave cursor_row unchanged when up and down pulses coincide, and leave cursor_col unchanged when left and right pulses coincide; a row move and a column move in the same cycle SHALL both apply.
REQ-015 SHALL implement a select FSM with two states, IDLE and SRC_HELD.
REQ-016 SHALL, in IDLE on a sel pulse, latch src_row and src_col from the cursor, enter SRC_HELD and raise src_held.
REQ-017 SHALL, in SRC_HELD on a sel pulse with cursor == src, cancel: return to IDLE, drop src_held, assert no move_valid, and leave src and dst unchanged.
REQ-018 SHALL, in SRC_HELD on a sel pulse with cursor != src, latch dst_row and dst_col, pulse move_valid for exactly one clock, and return to IDLE.
REQ-019 SHALL, when a sel pulse coincides with a movement pulse, use the pre-update cursor value for latching and comparison.
REQ-020 SHALL hold src and dst outputs stable between updates; move_valid SHALL never be high for two consecutive clocks.

Reset
REQ-021 SHALL, while reset is high, immediately force cursor_row, cursor_col, src_row, src_col, dst_row, dst_col, move_valid and src_held to 0, FSM to IDLE, and all synchronizer, debounce-level and counter state to 0.
REQ-022 SHALL, on reset mid-operation (including while in SRC_HELD or during a debounce count), abandon the pending move and emit no move_valid; a button still held at reset release SHALL produce one press pulse after the full debounce latency.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, SRC_HELD) and the constant BOARD_MAX = 7 in a shared package cursor_pkg.
REQ-024 SHALL implement synchronizer, debounce and edge-detect logic as one sub-module, button_debounce, instantiated five times with DEBOUNCE_CYCLES passed through.

Verification
REQ-025 SHALL cover, with DEBOUNCE_CYCLES=4: a clean btn_down press from reset -> cursor_row becomes 1 exactly 7 clocks after the edge; 8 presses -> cursor_row returns to 0.
REQ-026 SHALL cover: one btn_up press from reset -> cursor_row = 7; one btn_left press -> cursor_col = 7.
REQ-027 SHALL cover: btn_right bouncing high/low every 2 clocks for 20 clocks, then held -> exactly one increment of cursor_col.
REQ-028 SHALL cover: btn_up and btn_down pressed on the same clock -> cursor_row unchanged; btn_up and btn_right together -> row -1 and col +1.
REQ-029 SHALL cover: sel at (2,3), move to (4,3), sel -> a single move_valid pulse with src = (2,3) and dst = (4,3); sel and sel again at the same square -> src_held falls and no move_valid.
REQ-030 SHALL cover: reset asserted while in SRC_HELD -> all outputs 0 asynchronously, FSM in IDLE, no move_valid after release.
